counter_seq_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit counter datapath: loads a start value, counts up or down once per tick, and flags the terminal count. Supports one-shot and auto-reload modes, pause/resume and abort. Sits between software-style control strobes and the counter resource, as the block that owns counter run/stop policy.

---
 rtl/counter_seq_pkg.sv | 14 +
 rtl/counter_seq_presc.sv | 36 +++
 rtl/counter_seq_ctrl.sv | 115 +++++++++++
 tb/tb_counter_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - state encodings and direction constants for the counter sequencer
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_seq_presc.sv
// rtl/counter_seq_presc.sv - prescaler tick generator, used only when PRESCALER_EN is defined
module counter_seq_presc #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               enable,
    output logic               tick
);

    logic [PRESC_W-1:0] div_q;
    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == div_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                div_q <= presc_div;
            end
            // The wrap on tick also covers the clear required at reload.
            if (clear) begin
                cnt <= '0;
            end else if (enable) begin
                cnt <= tick ? '0 : cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - counter run/stop sequencer; optional prescaler under PRESCALER_EN
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef PRESCALER_EN
    ,
    parameter int PRESC_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
`ifdef PRESCALER_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           st;
    logic             tick;
    logic [WIDTH-1:0] term;

    assign state = st;
    assign term  = (dir == DIR_UP) ? {WIDTH{1'b1}} : '0;

`ifdef PRESCALER_EN
    logic start_acc;
    assign start_acc = start && (st == ST_IDLE || st == ST_DONE);

    counter_seq_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc | stop),
        .load      (start_acc),
        .presc_div (presc_div),
        .enable    (st == ST_RUN && !pause),
        .tick      (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        count <= load_val;
                        st    <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // start has no effect here, so pause still applies under it.
                    if (stop) begin
                        st   <= ST_IDLE;
                        busy <= 1'b0;
                    end else if (pause) begin
                        st <= ST_HOLD;
                    end else if (tick) begin
                        if (count == term) begin
                            done <= 1'b1;
                            if (auto_reload) begin
                                count <= load_val;
                            end else begin
                                st   <= ST_DONE;
                                busy <= 1'b0;
                            end
                        end else begin
                            count <= (dir == DIR_DOWN) ? count - ONE : count + ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        st   <= ST_IDLE;
                        busy <= 1'b0;
                    end else if (!pause) begin
                        st <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        st <= ST_IDLE;
                    end else if (start) begin
                        count <= load_val;
                        st    <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl (table, directed and random)
module tb_counter_seq_ctrl;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
    localparam int MAXV = MOD - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0, dir = 1'b1;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         busy, done;
    logic [1:0]   state;
`ifdef PRESCALER_EN
    logic [3:0]   presc_div = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .dir         (dir),
        .load_val    (load_val),
`ifdef PRESCALER_EN
        .presc_div   (presc_div),
`endif
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    typedef struct {
        logic       start, stop, pause, ar, dir;
        int         load;
        int         exp_count, exp_state, exp_busy, exp_done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int s, input int b, input int d);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".state"}, int'(state), s);
        check({tag, ".busy"},  int'(busy),  b);
        check({tag, ".done"},  int'(done),  d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Reference: phases named by the spec's state codes, count kept as plain modular integer.
    int m_phase, m_cnt, m_done;

    task automatic model_edge(input logic s, input logic p, input logic hp, input logic ar,
                              input logic d, input int ld);
        int term;
        m_done = 0;
        term   = d ? MAXV : 0;
        case (m_phase)
            0: if (s) begin m_cnt = ld; m_phase = 1; end
            1: begin
                if (p) m_phase = 0;
                else if (hp) m_phase = 2;
                else if (m_cnt == term) begin
                    m_done = 1;
                    if (ar) m_cnt = ld; else m_phase = 3;
                end else m_cnt = (m_cnt + (d ? 1 : MOD - 1)) % MOD;
            end
            2: if (p) m_phase = 0; else if (!hp) m_phase = 1;
            default: if (p) m_phase = 0; else if (s) begin m_cnt = ld; m_phase = 1; end
        endcase
    endtask

    initial begin
        // start, stop, pause, ar, dir, load, count, state, busy, done
        vecs[0]  = '{1, 0, 0, 0, 1, 13, 13, 1, 1, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 13, 14, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 13, 15, 1, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 13, 15, 3, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 1, 13, 15, 3, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 1, 15, 15, 1, 1, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 15, 15, 3, 0, 1};
        vecs[7]  = '{1, 0, 0, 0, 1, 8,  8,  1, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 1, 3,  9,  1, 1, 0};
        vecs[9]  = '{0, 1, 0, 0, 1, 3,  9,  0, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 1, 3,  9,  0, 0, 0};
        vecs[11] = '{1, 0, 0, 0, 0, 1,  1,  1, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 1,  0,  1, 1, 0};
        vecs[13] = '{0, 0, 0, 0, 1, 1,  1,  1, 1, 0};

        #2;
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            auto_reload = vecs[i].ar; dir = vecs[i].dir; load_val = W'(vecs[i].load);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_state,
                      vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Asynchronous reset mid-count, no clock edge in between.
        do_reset();
        start = 1'b1; load_val = 4'd0; dir = 1'b1; auto_reload = 1'b0;
        step();
        idle_inputs();
        for (int i = 0; i < 7; i++) step();
        check("async.pre_count", int'(count), 7);
        #1 rst = 1'b0;
        #1 check_all("async", 0, 0, 0, 0);
        #1 rst = 1'b1;
        step();

        // Auto-reload down: 2,1,0,2,1,0 with done on each reload.
        start = 1'b1; load_val = 4'd2; dir = 1'b0; auto_reload = 1'b1;
        step();
        idle_inputs();
        check_all("ar.start", 2, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_all($sformatf("ar%0d", i), (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2, 1, 1,
                      (i % 3 == 2) ? 1 : 0);
        end
        stop = 1'b1;
        step();
        idle_inputs();
        check_all("ar.stop", 2, 0, 0, 0);

        // Pause holds at 5, resume, then stop coincident with the terminal tick.
        start = 1'b1; load_val = 4'd3; dir = 1'b1; auto_reload = 1'b0;
        step();
        idle_inputs();
        step(); step();
        check("pause.pre", int'(count), 5);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("hold%0d", i), 5, 2, 1, 0);
        end
        pause = 1'b0;
        step();
        check_all("resume0", 5, 1, 1, 0);
        step();
        check_all("resume1", 6, 1, 1, 0);
        for (int i = 0; i < 9; i++) step();
        check("stopterm.pre", int'(count), 15);
        stop = 1'b1;
        step();
        idle_inputs();
        check_all("stopterm", 15, 0, 0, 0);
        step();
        check("stopterm.nodone", int'(done), 0);

`ifdef PRESCALER_EN
        presc_div = 4'd2;
        start = 1'b1; load_val = 4'd14; dir = 1'b1; auto_reload = 1'b0;
        step();
        idle_inputs();
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("presc.count%0d", i), int'(count), (i < 3) ? 14 : 15);
            check($sformatf("presc.done%0d", i), int'(done), (i == 6) ? 1 : 0);
        end
        check("presc.state", int'(state), 3);
        presc_div = 4'd0;
`endif

        // Random stimulus against the reference model.
        do_reset();
        m_phase = 0; m_cnt = 0; m_done = 0;
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom_range(7) == 0);
            stop        = ($urandom_range(15) == 0);
            pause       = ($urandom_range(4) == 0);
            auto_reload = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) dir = ~dir;
            load_val    = W'($urandom_range(MAXV));
            model_edge(start, stop, pause, auto_reload, dir, int'(load_val));
            step();
            check_all($sformatf("rnd%0d", i), m_cnt, m_phase,
                      (m_phase == 1 || m_phase == 2) ? 1 : 0, m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
